// File: rtl/rv32_prefetch_unit_if.sv
// Instruction-memory request/response bus and decode-side valid/ready bus of the prefetch unit.
// The master modport is the prefetch unit's view; slave is the memory/decode view.
interface rv32_prefetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_gnt, imem_rvalid, imem_rdata, out_ready
    );
endinterface

// File: rtl/rv32_prefetch_unit.sv
// RV32 fetch front-end: pipelined instruction-memory requests feeding a prefetch queue
// of {instr, pc}; a redirect flushes the queue and drops responses still in flight.
module rv32_prefetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH     = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    rv32_prefetch_unit_if.master         bus,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count,
    output logic                         err_unexpected_rsp
);
    localparam int unsigned AW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop_count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   instr_q [QUEUE_DEPTH];
    logic [31:0]   pc_q    [QUEUE_DEPTH];

    logic        can_issue;
    logic        xfer;
    logic        rsp;
    logic        push;
    logic        pop;
    logic [31:0] target_pc;
    logic        unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];
    assign target_pc      = {redirect_pc[31:2], 2'b00};

    // Credit rule: a request is only issued when a queue slot is reserved for its response.
    assign can_issue = (32'(outstanding) < MAX_OUTSTANDING) &&
                       (32'(outstanding) + 32'(count) < QUEUE_DEPTH);

    assign bus.imem_req  = !rst && !redirect_valid && can_issue;
    assign bus.imem_addr = fetch_pc;
    assign xfer          = bus.imem_req && bus.imem_gnt;

    // A response with nothing outstanding is flagged and otherwise ignored.
    assign rsp  = bus.imem_rvalid && (outstanding != '0);
    assign push = rsp && !redirect_valid && (drop_count == '0);
    assign pop  = (count != '0) && bus.out_ready && !redirect_valid;

    assign bus.out_valid = (count != '0);
    assign bus.out_instr = instr_q[rd_ptr];
    assign bus.out_pc    = pc_q[rd_ptr];
    assign queue_count   = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc           <= RESET_PC;
            resp_pc            <= RESET_PC;
            outstanding        <= '0;
            drop_count         <= '0;
            rd_ptr             <= '0;
            wr_ptr             <= '0;
            count              <= '0;
            err_unexpected_rsp <= 1'b0;
        end else begin
            if (bus.imem_rvalid && (outstanding == '0))
                err_unexpected_rsp <= 1'b1;

            case ({xfer, rsp})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase

            if (redirect_valid) begin
                fetch_pc   <= target_pc;
                resp_pc    <= target_pc;
                drop_count <= outstanding - OW'(rsp);
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
            end else begin
                if (xfer)
                    fetch_pc <= fetch_pc + 32'd4;
                if (rsp && (drop_count != '0))
                    drop_count <= drop_count - OW'(1);
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= bus.imem_rdata;
            pc_q[wr_ptr]    <= resp_pc;
        end
    end
endmodule
